// File: rtl/fifo_arbiter_pkg.sv
// ============================================================================
// Module   : fifo_arbiter_pkg
// Brief    : Shared widths and reset values for the two-channel FIFO arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_arbiter_pkg;
  localparam int DATA_W = 2;
  localparam int DEPTH  = 4;
  localparam int PTR_W  = 2;
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [DATA_W-1:0] OUT_RST        = 2'b00;
  localparam logic              LAST_GRANT_RST = 1'b1;
endpackage

`default_nettype wire

// File: rtl/fifo_arbiter_2ch_fifo_2bit.sv
// ============================================================================
// Module   : fifo_2bit
// Brief    : Single-channel FIFO; head word is presented combinationally.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_2bit
  import fifo_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              w_push_ok;
  logic              w_pop_ok;

  // A push into a full FIFO is dropped even when a pop frees a slot this cycle.
  always_comb begin
    w_push_ok = push & ~full_q;
    w_pop_ok  = pop & ~empty_q;
    wr_ptr_d  = wr_ptr_q + PTR_W'(w_push_ok);
    rd_ptr_d  = rd_ptr_q + PTR_W'(w_pop_ok);
    count_d   = count_q;
    if (w_push_ok && !w_pop_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (!w_push_ok && w_pop_ok) begin
      count_d = count_q - CNT_W'(1);
    end
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out = mem_q[rd_ptr_q];
  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;

endmodule

`default_nettype wire

// File: rtl/fifo_arbiter_2ch.sv
// ============================================================================
// Module   : fifo_arbiter_2ch
// Brief    : Two buffered 2-bit streams, round-robin arbitrated into a mux stage.
//            Optional sticky overflow flags: define FIFO_ARB_OVERFLOW_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_arbiter_2ch
  import fifo_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              push0,
  input  logic [DATA_W-1:0] data_in0,
  input  logic              push1,
  input  logic [DATA_W-1:0] data_in1,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out0,
  output logic [DATA_W-1:0] data_out1,
  output logic              selector,
  output logic              valid_out,
  output logic              full0,
  output logic              full1,
  output logic              empty0,
  output logic              empty1,
  output logic              overflow0,
  output logic              overflow1
);

  logic [DATA_W-1:0] w_head0, w_head1;
  logic [CNT_W-1:0]  w_cnt0, w_cnt1;
  logic              w_elig0, w_elig1;
  logic              w_grant, w_gnt_ch, w_pop0, w_pop1;

  logic [DATA_W-1:0] data_out0_q, data_out0_d;
  logic [DATA_W-1:0] data_out1_q, data_out1_d;
  logic              selector_q, selector_d;
  logic              last_grant_q, last_grant_d;
  logic              valid_out_q, valid_out_d;

  fifo_2bit u_fifo0 (
    .clk      (clk),
    .reset    (reset),
    .push     (push0),
    .data_in  (data_in0),
    .pop      (w_pop0),
    .data_out (w_head0),
    .full     (full0),
    .empty    (empty0),
    .count    (w_cnt0)
  );

  fifo_2bit u_fifo1 (
    .clk      (clk),
    .reset    (reset),
    .push     (push1),
    .data_in  (data_in1),
    .pop      (w_pop1),
    .data_out (w_head1),
    .full     (full1),
    .empty    (empty1),
    .count    (w_cnt1)
  );

  // On a tie the channel that did not win last time is served.
  always_comb begin
    w_elig0      = (w_cnt0 != '0);
    w_elig1      = (w_cnt1 != '0);
    w_grant      = pop & (w_elig0 | w_elig1);
    w_gnt_ch     = (w_elig0 & w_elig1) ? ~last_grant_q : w_elig1;
    w_pop0       = w_grant & ~w_gnt_ch;
    w_pop1       = w_grant & w_gnt_ch;
    data_out0_d  = w_pop0 ? w_head0 : data_out0_q;
    data_out1_d  = w_pop1 ? w_head1 : data_out1_q;
    selector_d   = w_grant ? w_gnt_ch : selector_q;
    last_grant_d = w_grant ? w_gnt_ch : last_grant_q;
    valid_out_d  = w_grant;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out0_q  <= OUT_RST;
      data_out1_q  <= OUT_RST;
      selector_q   <= 1'b0;
      last_grant_q <= LAST_GRANT_RST;
      valid_out_q  <= 1'b0;
    end else begin
      data_out0_q  <= data_out0_d;
      data_out1_q  <= data_out1_d;
      selector_q   <= selector_d;
      last_grant_q <= last_grant_d;
      valid_out_q  <= valid_out_d;
    end
  end

  assign data_out0 = data_out0_q;
  assign data_out1 = data_out1_q;
  assign selector  = selector_q;
  assign valid_out = valid_out_q;

`ifdef FIFO_ARB_OVERFLOW_EN
  logic overflow0_q, overflow0_d;
  logic overflow1_q, overflow1_d;

  always_comb begin
    overflow0_d = overflow0_q | (push0 & full0);
    overflow1_d = overflow1_q | (push1 & full1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow0_q <= 1'b0;
      overflow1_q <= 1'b0;
    end else begin
      overflow0_q <= overflow0_d;
      overflow1_q <= overflow1_d;
    end
  end

  assign overflow0 = overflow0_q;
  assign overflow1 = overflow1_q;
`else
  assign overflow0 = 1'b0;
  assign overflow1 = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_arbiter_2ch.sv
// ============================================================================
// Module   : tb_fifo_arbiter_2ch
// Brief    : Queue-based reference model with scoreboard for fifo_arbiter_2ch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_arbiter_2ch;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       push0 = 1'b0, push1 = 1'b0, pop = 1'b0;
  logic [1:0] data_in0 = 2'b00, data_in1 = 2'b00;
  logic [1:0] data_out0, data_out1;
  logic       selector, valid_out;
  logic       full0, full1, empty0, empty1, overflow0, overflow1;

  always #5 clk = ~clk;

  fifo_arbiter_2ch dut (
    .clk       (clk),
    .reset     (reset),
    .push0     (push0),
    .data_in0  (data_in0),
    .push1     (push1),
    .data_in1  (data_in1),
    .pop       (pop),
    .data_out0 (data_out0),
    .data_out1 (data_out1),
    .selector  (selector),
    .valid_out (valid_out),
    .full0     (full0),
    .full1     (full1),
    .empty0    (empty0),
    .empty1    (empty1),
    .overflow0 (overflow0),
    .overflow1 (overflow1)
  );

  typedef struct packed {
    logic       ch;
    logic [1:0] d;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] q0[$];
  logic [1:0] q1[$];
  logic [1:0] m_do0, m_do1;
  logic       m_sel, m_last, m_ov0, m_ov1;
  int         checks = 0;
  int         errors = 0;

  function automatic void model_reset();
    q0.delete();
    q1.delete();
    exp_q.delete();
    m_do0  = 2'b00;
    m_do1  = 2'b00;
    m_sel  = 1'b0;
    m_last = 1'b1;
    m_ov0  = 1'b0;
    m_ov1  = 1'b0;
  endfunction

  // One clock of the reference: grant from the pre-edge occupancy, then pushes.
  function automatic void model_update();
    bit         e0, e1, f0, f1, g;
    logic [1:0] w;
    e0 = (q0.size() != 0);
    e1 = (q1.size() != 0);
    f0 = (q0.size() == DEPTH);
    f1 = (q1.size() == DEPTH);
    if (pop && (e0 || e1)) begin
      g = (e0 && e1) ? !m_last : e1;
      if (g) begin
        w = q1.pop_front();
        m_do1 = w;
      end else begin
        w = q0.pop_front();
        m_do0 = w;
      end
      m_sel  = g;
      m_last = g;
      exp_q.push_back({g, w});
    end
    if (push0) begin
      if (!f0) q0.push_back(data_in0);
`ifdef FIFO_ARB_OVERFLOW_EN
      else m_ov0 = 1'b1;
`endif
    end
    if (push1) begin
      if (!f1) q1.push_back(data_in1);
`ifdef FIFO_ARB_OVERFLOW_EN
      else m_ov1 = 1'b1;
`endif
    end
  endfunction

  task automatic step(input logic p0, input logic [1:0] d0,
                      input logic p1, input logic [1:0] d1, input logic pp);
    push0 = p0; data_in0 = d0;
    push1 = p1; data_in1 = d1;
    pop   = pp;
    @(posedge clk);
    model_update();
    #2;
  endtask

  task automatic do_reset();
    push0 = 1'b0; push1 = 1'b0; pop = 1'b0;
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: full visible state every cycle, plus scoreboard pop on each valid_out.
  always @(negedge clk) begin
    logic [10:0] act_v, exp_v;
    exp_t        e;
    act_v = {data_out0, data_out1, selector, empty0, empty1, full0, full1, overflow0, overflow1};
    exp_v = {m_do0, m_do1, m_sel, q0.size() == 0, q1.size() == 0,
             q0.size() == DEPTH, q1.size() == DEPTH, m_ov0, m_ov1};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL state: got %b expected %b at %0t", act_v, exp_v, $time);
    end
    checks++;
    if (valid_out) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL grant: got valid_out=1 expected no grant at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        if (selector !== e.ch || (selector ? data_out1 : data_out0) !== e.d) begin
          errors++;
          $display("FAIL grant: got ch%0d data %b expected ch%0d data %b at %0t",
                   selector, selector ? data_out1 : data_out0, e.ch, e.d, $time);
        end
      end
    end else if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL grant: got valid_out=0 expected ch%0d data %b at %0t",
               exp_q[0].ch, exp_q[0].d, $time);
      exp_q.delete();
    end
  end

  initial begin
    model_reset();
    do_reset();

    // single channel stream
    step(1, 2'b01, 0, 2'b00, 1);
    step(1, 2'b10, 0, 2'b00, 1);
    step(1, 2'b11, 0, 2'b00, 1);
    repeat (3) step(0, 2'b00, 0, 2'b00, 1);

    // round-robin from a fresh tie
    do_reset();
    step(1, 2'b00, 1, 2'b10, 0);
    step(1, 2'b01, 1, 2'b11, 0);
    repeat (5) step(0, 2'b00, 0, 2'b00, 1);

    // backpressure on channel 1
    step(0, 2'b00, 1, 2'b01, 0);
    step(0, 2'b00, 1, 2'b10, 0);
    step(0, 2'b00, 1, 2'b11, 0);
    repeat (5) step(0, 2'b00, 0, 2'b00, 0);
    repeat (4) step(0, 2'b00, 0, 2'b00, 1);

    // fill past full, drain, then wrap pointers
    for (int i = 0; i < 5; i++) step(1, 2'(i), 0, 2'b00, 0);
    repeat (5) step(0, 2'b00, 0, 2'b00, 1);
    for (int i = 0; i < 10; i++) step(1, 2'(i), 0, 2'b00, 1);
    repeat (3) step(0, 2'b00, 0, 2'b00, 1);

    // push and pop together on a single-entry FIFO
    step(1, 2'b01, 0, 2'b00, 0);
    step(1, 2'b10, 0, 2'b00, 1);
    step(0, 2'b00, 0, 2'b00, 1);
    step(0, 2'b00, 0, 2'b00, 0);

    // asynchronous reset with three words stored in FIFO0
    step(1, 2'b11, 0, 2'b00, 0);
    step(0, 2'b00, 0, 2'b00, 1);
    step(1, 2'b01, 1, 2'b10, 0);
    step(1, 2'b10, 0, 2'b00, 0);
    step(1, 2'b11, 0, 2'b00, 0);
    #5;
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_data_out0", 16'(data_out0), 16'h0);
    chk("rst_data_out1", 16'(data_out1), 16'h0);
    chk("rst_selector",  16'(selector),  16'h0);
    chk("rst_valid_out", 16'(valid_out), 16'h0);
    chk("rst_empty0",    16'(empty0),    16'h1);
    chk("rst_empty1",    16'(empty1),    16'h1);
    chk("rst_full0",     16'(full0),     16'h0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    step(0, 2'b00, 0, 2'b00, 1);
    step(0, 2'b00, 0, 2'b00, 1);
    chk("post_rst_valid", 16'(valid_out), 16'h0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 2'($urandom()),
           1'($urandom_range(0, 1)), 2'($urandom()),
           1'($urandom_range(0, 3) != 0));
    end
    repeat (10) step(0, 2'b00, 0, 2'b00, 1);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 16'(exp_q.size()), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_arbiter_2ch.md
Name: fifo_arbiter_2ch

Overview:
- Upstream feeder for the 2x1 registered mux stage.
- Buffers two independent 2-bit input streams in per-channel FIFOs.
- Round-robin arbitrates between the two channels and drives data_out0/data_out1/selector straight into the mux stage's data_in0/data_in1/selector.
- valid_out marks the cycles in which the presented word is new.

Parameters:
- DATA_W, 2, width of each channel word.
- DEPTH, 4, entries per channel FIFO; power of two.
- PTR_W, 2, log2(DEPTH); occupancy counters are PTR_W+1 bits.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- push0  in  1  write request, channel 0.
- data_in0  in  DATA_W  write data, channel 0.
- push1  in  1  write request, channel 1.
- data_in1  in  DATA_W  write data, channel 1.
- pop  in  1  downstream ready; permits one grant this cycle.
- data_out0  out  DATA_W  last word granted from channel 0 (to mux in_0).
- data_out1  out  DATA_W  last word granted from channel 1 (to mux in_1).
- selector  out  1  channel of the most recent grant.
- valid_out  out  1  one-cycle pulse: a new word was granted last cycle.
- full0, full1  out  1  FIFO holds DEPTH entries.
- empty0, empty1  out  1  FIFO holds 0 entries.
- overflow0, overflow1  out  1  sticky overflow flags (see Optional Feature).

Behaviour:
- Reset (asynchronous, active-high):
  - Pointers and counts to 0.
  - data_out0 = data_out1 = 2'b00, selector = 0, valid_out = 0.
  - empty0 = empty1 = 1, full0 = full1 = 0.
  - last_grant = 1, so channel 0 wins the first tie.
  - Reset asserted mid-operation discards all stored words immediately.
- Push:
  - pushN with fullN = 0 writes data_inN at wr_ptr, increments wr_ptr (wraps DEPTH-1 -> 0) and increments count.
  - pushN with fullN = 1 drops the word, even if the same channel is popped that cycle.
- Grant eligibility: a channel is eligible when its count > 0 at the clock edge. A word pushed in cycle N is first eligible in cycle N+1.
- Arbitration (only when pop = 1):
  - Both eligible: grant = ~last_grant.
  - One eligible: grant that channel.
  - None eligible: no grant.
- On a grant to channel g:
  - Read the head and advance rd_ptr (with wrap).
  - Decrement the count, except when a same-cycle accepted push leaves it unchanged.
  - Register the word into data_out[g]; the other data_out holds.
  - selector <= g, last_grant <= g, valid_out <= 1.
- No grant: valid_out <= 0; data_out0, data_out1 and selector hold.
- Latency: push to valid_out is 2 cycles minimum (push N, grant N+1, outputs visible N+2).
- Flags: fullN/emptyN are registered from the updated count, so they are accurate in the cycle after the update.
- Continuous pop with both channels backlogged alternates 0,1,0,1...

Optional Feature:
- Macro: FIFO_ARB_OVERFLOW_EN.
- Defined:
  - overflowN sets on any pushN while fullN = 1.
  - The flag is sticky until reset.
- Undefined:
  - overflow0/overflow1 are tied to 0.
  - No overflow logic is synthesised.
- Drop behaviour is identical in both builds.

Decomposition:
- Package fifo_arbiter_pkg: DATA_W, DEPTH, PTR_W constants and the reset values (OUT_RST = 2'b00, LAST_GRANT_RST = 1).
- Sub-module fifo_2bit: one-channel FIFO with push/pop/data/full/empty/count outputs.
  - Instantiated twice.
  - Arbitration and output registers live in the top.

Test Plan:
- Reset: assert reset mid-stream with 3 words in FIFO0. Required: outputs go to 0 immediately, empty0 = 1; after release, pop = 1 gives valid_out = 0.
- Single channel: push0 2'b01, 2'b10, 2'b11 on consecutive cycles, pop = 1 throughout. Required: data_out0 = 01, 10, 11 on cycles 2, 3, 4 after the first push, selector = 0, valid_out = 1 for 3 cycles.
- Round-robin: preload FIFO0 {00, 01} and FIFO1 {10, 11}, then hold pop = 1. Required: grants ch0:00, ch1:10, ch0:01, ch1:11; selector toggles 0, 1, 0, 1.
- Backpressure: FIFO1 holds 3 words, pop = 0 for 5 cycles. Required: valid_out = 0 and outputs hold; with pop = 1, words emerge in order.
- Full/wrap: push 5 words 0, 1, 2, 3, 0 into FIFO0 with pop = 0. Required: full0 = 1 after 4 pushes, 5th word dropped, overflow0 = 1 only with FIFO_ARB_OVERFLOW_EN; draining gives 0, 1, 2, 3. Push/drain 10 more words to exercise pointer wrap.
- Simultaneous push and pop on a count = 1 FIFO. Required: count stays 1, emptyN stays 0, next grant returns the newly pushed word.
